// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback formatter for the RV32I pipeline.
// Registers the MEM-stage result and aligns and extends load data. It drives the
// register-file write port, the forwarding taps and the retired-instruction counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [1:0]       mem_wbsel,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_word,
  input  logic [XLEN-1:0]  mem_pc4,
  input  logic [2:0]       mem_funct3,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       writereg,
  output logic [XLEN-1:0]  writedata,
  output logic             RegWrite,
  output logic             wb_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret
);

  // Formats one load. Returns {fault, data}. A fault is a misaligned half or word
  // access, or an undefined size code. Faulting loads return zero data.
  function automatic logic [32:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  a,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [32:0] r;
    r = {1'b0, 32'h0000_0000};
    case (a)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000: r = {1'b0, {24{b[7]}}, b};
      3'b100: r = {1'b0, 24'h00_0000, b};
      3'b001: begin
        if (a[0]) r = {1'b1, 32'h0000_0000};
        else      r = {1'b0, {16{h[15]}}, h};
      end
      3'b101: begin
        if (a[0]) r = {1'b1, 32'h0000_0000};
        else      r = {1'b0, 16'h0000, h};
      end
      3'b010: begin
        if (a != 2'b00) r = {1'b1, 32'h0000_0000};
        else            r = {1'b0, word};
      end
      default: r = {1'b1, 32'h0000_0000};
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] result_s;
  logic            fault_s;

  // Result select: ALU, formatted load or link value. The reserved code faults.
  always_comb begin
    result_s = {XLEN{1'b0}};
    fault_s  = 1'b0;
    case (mem_wbsel)
      2'b00:   result_s = mem_alu_result;
      2'b01:   {fault_s, result_s} = format_load(mem_load_word, mem_alu_result[1:0], mem_funct3);
      2'b10:   result_s = mem_pc4;
      default: fault_s  = 1'b1;
    endcase
  end

  // WB register. Priority is flush, then stall, then capture. An invalid capture
  // acts as a bubble. A stall suppresses the error pulse so that it never repeats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writereg     <= 5'd0;
      writedata    <= {XLEN{1'b0}};
      RegWrite     <= 1'b0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      instret      <= {CNT_W{1'b0}};
    end else if (flush || (!stall && !mem_valid)) begin
      writereg     <= 5'd0;
      writedata    <= {XLEN{1'b0}};
      RegWrite     <= 1'b0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else if (stall) begin
      misalign_err <= 1'b0;
    end else begin
      wb_valid     <= 1'b1;
      writereg     <= mem_rd;
      writedata    <= fault_s ? {XLEN{1'b0}} : result_s;
      RegWrite     <= mem_regwrite && !fault_s && (mem_rd != 5'd0);
      misalign_err <= fault_s;
      if (!fault_s) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage, with a CNT_W=4 copy for wrap.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0, mem_regwrite = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic [1:0]  mem_wbsel = 2'b00;
  logic [31:0] mem_alu_result = 32'd0, mem_load_word = 32'd0, mem_pc4 = 32'd0;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [4:0]  writereg, writereg4;
  logic [31:0] writedata, writedata4;
  logic        RegWrite, wb_valid, misalign_err, RegWrite4, wb_valid4, misalign_err4;
  logic [31:0] instret;
  logic [3:0]  instret4;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_cnt = 32'd0;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_wbsel(mem_wbsel), .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
    .mem_pc4(mem_pc4), .mem_funct3(mem_funct3), .stall(stall), .flush(flush),
    .writereg(writereg), .writedata(writedata), .RegWrite(RegWrite), .wb_valid(wb_valid),
    .misalign_err(misalign_err), .instret(instret));

  wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_wbsel(mem_wbsel), .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
    .mem_pc4(mem_pc4), .mem_funct3(mem_funct3), .stall(stall), .flush(flush),
    .writereg(writereg4), .writedata(writedata4), .RegWrite(RegWrite4), .wb_valid(wb_valid4),
    .misalign_err(misalign_err4), .instret(instret4));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                       input logic [2:0] f3);
    mem_valid = v; mem_rd = rd; mem_regwrite = rw; mem_wbsel = sel;
    mem_alu_result = alu; mem_load_word = ld; mem_pc4 = pc4; mem_funct3 = f3;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 5'($urandom), 1'b1, 2'($urandom), $urandom, $urandom, $urandom, 3'($urandom));
    tick(); tick();
    tests++;
    if ({writereg, writedata, RegWrite, wb_valid, misalign_err, instret} !== 72'd0) begin
      fails++; $display("FAIL reset_outputs: got rd=%0d wd=%h rw=%b v=%b err=%b cnt=%0d required all 0",
                        writereg, writedata, RegWrite, wb_valid, misalign_err, instret);
    end
    rst = 1'b1;
    exp_cnt = 32'd0;
    drive(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'd0, 32'd0, 3'b000);
    tick();
    exp_cnt++;
    tests++;
    if ({writereg, writedata, RegWrite, wb_valid, instret} !== {5'd5, 32'h1234_5678, 1'b1, 1'b1, exp_cnt}) begin
      fails++; $display("FAIL first_capture: got rd=%0d wd=%h rw=%b v=%b cnt=%0d required rd=5 wd=12345678 rw=1 v=1 cnt=%0d",
                        writereg, writedata, RegWrite, wb_valid, instret, exp_cnt);
    end
  endtask

  task automatic test_load();
    logic [31:0] addr [5] = '{32'h0000_1003, 32'h0000_1001, 32'h0000_1002, 32'h0000_1000, 32'h0000_1000};
    logic [2:0]  f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] expd [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 10), 1'b1, 2'b01, addr[i], 32'h80FF_7F01, 32'd0, f3[i]);
      tick();
      exp_cnt++;
      tests++;
      if ({writedata, RegWrite, misalign_err, instret} !== {expd[i], 1'b1, 1'b0, exp_cnt}) begin
        fails++; $display("FAIL load_%0d: got wd=%h rw=%b err=%b cnt=%0d required wd=%h rw=1 err=0 cnt=%0d",
                          i, writedata, RegWrite, misalign_err, instret, expd[i], exp_cnt);
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] addr [4] = '{32'h0000_2002, 32'h0000_2001, 32'h0000_2000, 32'h0000_2000};
    logic [2:0]  f3   [4] = '{3'b010, 3'b001, 3'b011, 3'b000};
    logic [1:0]  sel  [4] = '{2'b01, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 1'b1, sel[i], addr[i], 32'h80FF_7F01, 32'h0000_0100, f3[i]);
      tick();
      tests++;
      if ({writedata, RegWrite, misalign_err, wb_valid, instret} !== {32'd0, 1'b0, 1'b1, 1'b1, exp_cnt}) begin
        fails++; $display("FAIL fault_%0d: got wd=%h rw=%b err=%b v=%b cnt=%0d required wd=0 rw=0 err=1 v=1 cnt=%0d",
                          i, writedata, RegWrite, misalign_err, wb_valid, instret, exp_cnt);
      end
      drive(1'b1, 5'd4, 1'b1, 2'b00, 32'h0000_00AA, 32'd0, 32'd0, 3'b000);
      tick();
      exp_cnt++;
      tests++;
      if ({misalign_err, RegWrite, instret} !== {1'b0, 1'b1, exp_cnt}) begin
        fails++; $display("FAIL fault_pulse_end_%0d: got err=%b rw=%b cnt=%0d required err=0 rw=1 cnt=%0d",
                          i, misalign_err, RegWrite, instret, exp_cnt);
      end
    end
  endtask

  task automatic test_x0_link();
    drive(1'b1, 5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'd0, 32'd0, 3'b000);
    tick();
    exp_cnt++;
    tests++;
    if ({writereg, RegWrite, wb_valid, instret} !== {5'd0, 1'b0, 1'b1, exp_cnt}) begin
      fails++; $display("FAIL x0_write: got rd=%0d rw=%b v=%b cnt=%0d required rd=0 rw=0 v=1 cnt=%0d",
                        writereg, RegWrite, wb_valid, instret, exp_cnt);
    end
    drive(1'b1, 5'd1, 1'b1, 2'b10, 32'h0000_5555, 32'd0, 32'h0000_0104, 3'b000);
    tick();
    exp_cnt++;
    tests++;
    if ({writereg, writedata, RegWrite, instret} !== {5'd1, 32'h0000_0104, 1'b1, exp_cnt}) begin
      fails++; $display("FAIL link: got rd=%0d wd=%h rw=%b cnt=%0d required rd=1 wd=00000104 rw=1 cnt=%0d",
                        writereg, writedata, RegWrite, instret, exp_cnt);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 5'd7, 1'b1, 2'b00, 32'h0000_CAFE, 32'd0, 32'd0, 3'b000);
    tick();
    exp_cnt++;
    stall = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 2'b00, 32'h1111_1111, 32'd0, 32'd0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({writereg, writedata, RegWrite, wb_valid, instret} !== {5'd7, 32'h0000_CAFE, 1'b1, 1'b1, exp_cnt}) begin
        fails++; $display("FAIL stall_hold_%0d: got rd=%0d wd=%h rw=%b v=%b cnt=%0d required rd=7 wd=0000cafe rw=1 v=1 cnt=%0d",
                          i, writereg, writedata, RegWrite, wb_valid, instret, exp_cnt);
      end
    end
    stall = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 2'b01, 32'h0000_0003, 32'h80FF_7F01, 32'd0, 3'b010);
    tick();
    stall = 1'b1;
    tick();
    tests++;
    if ({misalign_err, instret} !== {1'b0, exp_cnt}) begin
      fails++; $display("FAIL stall_err_once: got err=%b cnt=%0d required err=0 cnt=%0d", misalign_err, instret, exp_cnt);
    end
    drive(1'b1, 5'd9, 1'b1, 2'b00, 32'h2222_2222, 32'd0, 32'd0, 3'b000);
    flush = 1'b1;
    tick();
    tests++;
    if ({writereg, writedata, RegWrite, wb_valid, instret} !== {5'd0, 32'd0, 1'b0, 1'b0, exp_cnt}) begin
      fails++; $display("FAIL flush_stall: got rd=%0d wd=%h rw=%b v=%b cnt=%0d required all 0 cnt=%0d",
                        writereg, writedata, RegWrite, wb_valid, instret, exp_cnt);
    end
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 5'd9, 1'b1, 2'b00, 32'h3333_3333, 32'd0, 32'd0, 3'b000);
    tick();
    tests++;
    if ({wb_valid, RegWrite, instret} !== {1'b0, 1'b0, exp_cnt}) begin
      fails++; $display("FAIL bubble: got v=%b rw=%b cnt=%0d required v=0 rw=0 cnt=%0d", wb_valid, RegWrite, instret, exp_cnt);
    end
    drive(1'b1, 5'd6, 1'b1, 2'b00, 32'h4444_4444, 32'd0, 32'd0, 3'b000);
    tick();
    #3 rst = 1'b0;
    #1;
    exp_cnt = 32'd0;
    tests++;
    if ({writereg, writedata, RegWrite, wb_valid, misalign_err, instret} !== 72'd0) begin
      fails++; $display("FAIL async_reset: got rd=%0d wd=%h rw=%b v=%b cnt=%0d required all 0",
                        writereg, writedata, RegWrite, wb_valid, instret);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_wrap();
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 3'b000);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 5'd2, 1'b1, 2'b00, 32'(i), 32'd0, 32'd0, 3'b000);
      tick();
    end
    tests++;
    if (instret4 !== 4'd15) begin
      fails++; $display("FAIL wrap_top: got %0d required 15", instret4);
    end
    tick();
    tests++;
    if ({instret4, instret} !== {4'd0, 32'd16}) begin
      fails++; $display("FAIL wrap: got cnt4=%0d cnt=%0d required cnt4=0 cnt=16", instret4, instret);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_faults();
    test_x0_link();
    test_stall_flush();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
